// File: rtl/ifetch_responder.sv
// Memory-side fetch responder: window-checks PC requests, issues one read to a
// fixed-latency instruction memory, and serves repeats from a one-entry buffer.
module ifetch_responder #(
    parameter logic [31:0] ADDR_LO     = 32'd212,
    parameter logic [31:0] ADDR_HI     = 32'd255,
    parameter int unsigned MEM_LATENCY = 3,
    parameter int unsigned MEM_AW      = 8,
    parameter logic [31:0] NOP_WORD    = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req,
    input  logic [31:0]       addr_in,
    input  logic              flush,
    output logic              mem_en,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       instr,
    output logic              instr_valid,
    output logic              stall,
    output logic              fault
);

    localparam int unsigned CNT_W  = 4;
    localparam logic [0:0]  S_IDLE = 1'b0;
    localparam logic [0:0]  S_BUSY = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mem_en_q, mem_en_d;
    logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       instr_q, instr_d;
    logic              instr_valid_q, instr_valid_d;
    logic              stall_q, stall_d;
    logic              fault_q, fault_d;
    logic              buf_valid_q, buf_valid_d;
    logic [31:0]       buf_addr_q, buf_addr_d;
    logic [31:0]       buf_data_q, buf_data_d;
    logic              in_window_c;
    logic              buf_hit_c;

    assign in_window_c = (addr_in >= ADDR_LO) && (addr_in <= ADDR_HI);
    assign buf_hit_c   = buf_valid_q && (addr_in == buf_addr_q);

    // Next-state and registered-output logic; pulses default low every cycle.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        mem_en_d      = 1'b0;
        mem_addr_d    = mem_addr_q;
        addr_d        = addr_q;
        instr_d       = instr_q;
        instr_valid_d = 1'b0;
        stall_d       = stall_q;
        fault_d       = 1'b0;
        buf_valid_d   = buf_valid_q;
        buf_addr_d    = buf_addr_q;
        buf_data_d    = buf_data_q;

        case (state_q)
            S_IDLE: begin
                stall_d = 1'b0;
                // A flush on the same edge drops the request entirely.
                if (req && !flush) begin
                    if (!in_window_c) begin
                        fault_d = 1'b1;
                        instr_d = NOP_WORD;
                    end else if (buf_hit_c) begin
                        instr_d       = buf_data_q;
                        instr_valid_d = 1'b1;
                    end else begin
                        state_d    = S_BUSY;
                        mem_en_d   = 1'b1;
                        mem_addr_d = addr_in[MEM_AW-1:0];
                        addr_d     = addr_in;
                        stall_d    = 1'b1;
                        cnt_d      = CNT_W'(MEM_LATENCY);
                    end
                end
            end
            S_BUSY: begin
                if (flush) begin
                    state_d = S_IDLE;
                    stall_d = 1'b0;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d       = S_IDLE;
                    stall_d       = 1'b0;
                    cnt_d         = '0;
                    instr_d       = mem_rdata;
                    instr_valid_d = 1'b1;
                    buf_valid_d   = 1'b1;
                    buf_addr_d    = addr_q;
                    buf_data_d    = mem_rdata;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                stall_d = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            mem_en_q      <= 1'b0;
            mem_addr_q    <= '0;
            addr_q        <= '0;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            stall_q       <= 1'b0;
            fault_q       <= 1'b0;
            buf_valid_q   <= 1'b0;
            buf_addr_q    <= '0;
            buf_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            mem_en_q      <= mem_en_d;
            mem_addr_q    <= mem_addr_d;
            addr_q        <= addr_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            stall_q       <= stall_d;
            fault_q       <= fault_d;
            buf_valid_q   <= buf_valid_d;
            buf_addr_q    <= buf_addr_d;
            buf_data_q    <= buf_data_d;
        end
    end

    assign mem_en      = mem_en_q;
    assign mem_addr    = mem_addr_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign stall       = stall_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_ifetch_responder.sv
// Directed bench for ifetch_responder: miss/hit/fault/flush/reset scenarios
// with hand-computed cycle counts at MEM_LATENCY=3.
module tb_ifetch_responder;

    logic        clk;
    logic        reset_n;
    logic        req;
    logic [31:0] addr_in;
    logic        flush;
    logic        mem_en;
    logic [7:0]  mem_addr;
    logic [31:0] mem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        stall;
    logic        fault;

    int n_vec;
    int n_err;

    // Per-request observations collected by run_req.
    int          r_stall;
    int          r_memen;
    int          r_valid;
    int          r_fault;
    logic [7:0]  r_maddr;
    logic [31:0] r_vinstr;

    ifetch_responder dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req),
        .addr_in    (addr_in),
        .flush      (flush),
        .mem_en     (mem_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .instr      (instr),
        .instr_valid(instr_valid),
        .stall      (stall),
        .fault      (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        if (stall) r_stall++;
        if (mem_en) begin
            r_memen++;
            r_maddr = mem_addr;
        end
        if (instr_valid) begin
            r_valid++;
            r_vinstr = instr;
        end
        if (fault) r_fault++;
    endtask

    // Issue one request (sampled at E0) and observe 8 post-edge samples.
    // flush_edge: 0 = flush with the request at E0, k>0 = flush at BUSY edge Ek, -1 = none.
    task automatic run_req(input logic [31:0] a, input logic [31:0] rd, input int flush_edge);
        r_stall  = 0;
        r_memen  = 0;
        r_valid  = 0;
        r_fault  = 0;
        r_maddr  = 8'hxx;
        r_vinstr = 32'hxxxx_xxxx;
        mem_rdata = rd;
        addr_in   = a;
        req       = 1'b1;
        flush     = (flush_edge == 0);
        tick();
        sample();
        req = 1'b0;
        for (int i = 1; i < 8; i++) begin
            flush = (flush_edge == i);
            tick();
            sample();
        end
        flush = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req = 1'b0; flush = 1'b0; addr_in = '0; mem_rdata = '0;
        #12;
        n_vec++;
        if ({mem_en, instr_valid, stall, fault} !== 4'b0000 || instr !== 32'h0 || mem_addr !== 8'h00) begin
            n_err++;
            $display("FAIL reset_state: en=%b v=%b st=%b f=%b instr=%h maddr=%h, required all 0",
                     mem_en, instr_valid, stall, fault, instr, mem_addr);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_miss_first();
        run_req(32'd212, 32'hDEADBEEF, -1);
        n_vec++;
        if (r_memen !== 1 || r_maddr !== 8'hD4) begin
            n_err++;
            $display("FAIL miss212_mem_en: pulses=%0d addr=%h, required 1 / d4", r_memen, r_maddr);
        end
        n_vec++;
        if (r_stall !== 3) begin
            n_err++;
            $display("FAIL miss212_stall: %0d cycles, required 3", r_stall);
        end
        n_vec++;
        if (r_valid !== 1 || r_vinstr !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL miss212_data: valid=%0d instr=%h, required 1 / deadbeef", r_valid, r_vinstr);
        end
    endtask

    task automatic test_fault();
        run_req(32'd211, 32'h5555_5555, -1);
        n_vec++;
        if (r_fault !== 1 || r_valid !== 0 || r_memen !== 0 || instr !== 32'h0) begin
            n_err++;
            $display("FAIL fault211: f=%0d v=%0d en=%0d instr=%h, required 1/0/0/0", r_fault, r_valid, r_memen, instr);
        end
        run_req(32'd256, 32'h5555_5555, -1);
        n_vec++;
        if (r_fault !== 1 || r_valid !== 0 || r_memen !== 0 || r_stall !== 0 || instr !== 32'h0) begin
            n_err++;
            $display("FAIL fault256: f=%0d v=%0d en=%0d st=%0d instr=%h, required 1/0/0/0/0",
                     r_fault, r_valid, r_memen, r_stall, instr);
        end
    endtask

    task automatic test_hit();
        run_req(32'd212, 32'h0BAD_0BAD, -1);
        n_vec++;
        if (r_valid !== 1 || r_vinstr !== 32'hDEADBEEF || r_memen !== 0 || r_stall !== 0 || r_fault !== 0) begin
            n_err++;
            $display("FAIL hit212: v=%0d instr=%h en=%0d st=%0d f=%0d, required 1/deadbeef/0/0/0",
                     r_valid, r_vinstr, r_memen, r_stall, r_fault);
        end
        run_req(32'd213, 32'h1234_5678, -1);
        n_vec++;
        if (r_memen !== 1 || r_maddr !== 8'hD5 || r_stall !== 3 || r_valid !== 1 || r_vinstr !== 32'h1234_5678) begin
            n_err++;
            $display("FAIL miss213: en=%0d addr=%h st=%0d v=%0d instr=%h, required 1/d5/3/1/12345678",
                     r_memen, r_maddr, r_stall, r_valid, r_vinstr);
        end
    endtask

    task automatic test_flush_busy();
        run_req(32'd220, 32'hAAAA_0220, 2);
        n_vec++;
        if (r_stall !== 2 || r_valid !== 0 || instr !== 32'h1234_5678) begin
            n_err++;
            $display("FAIL flush_e2: st=%0d v=%0d instr=%h, required 2/0/12345678", r_stall, r_valid, instr);
        end
        run_req(32'd220, 32'h2200_00AA, -1);
        n_vec++;
        if (r_memen !== 1 || r_stall !== 3 || r_valid !== 1 || r_vinstr !== 32'h2200_00AA) begin
            n_err++;
            $display("FAIL refetch220: en=%0d st=%0d v=%0d instr=%h, required 1/3/1/220000aa",
                     r_memen, r_stall, r_valid, r_vinstr);
        end
    endtask

    task automatic test_flush_capture();
        run_req(32'd230, 32'hCCCC_0230, 3);
        n_vec++;
        if (r_stall !== 3 || r_valid !== 0 || instr !== 32'h2200_00AA) begin
            n_err++;
            $display("FAIL flush_cap: st=%0d v=%0d instr=%h, required 3/0/220000aa", r_stall, r_valid, instr);
        end
        // Buffer must still hold 220 after the flushed capture.
        run_req(32'd220, 32'h0BAD_0BAD, -1);
        n_vec++;
        if (r_valid !== 1 || r_vinstr !== 32'h2200_00AA || r_memen !== 0) begin
            n_err++;
            $display("FAIL hit220_after_flush: v=%0d instr=%h en=%0d, required 1/220000aa/0", r_valid, r_vinstr, r_memen);
        end
        run_req(32'd230, 32'h0BAD_0BAD, 0);
        n_vec++;
        if (r_memen !== 0 || r_fault !== 0 || r_valid !== 0 || r_stall !== 0) begin
            n_err++;
            $display("FAIL idle_req_flush: en=%0d f=%0d v=%0d st=%0d, required all 0", r_memen, r_fault, r_valid, r_stall);
        end
        run_req(32'd300, 32'h0BAD_0BAD, 0);
        n_vec++;
        if (r_fault !== 0 || instr !== 32'h2200_00AA) begin
            n_err++;
            $display("FAIL idle_flush_bad_addr: f=%0d instr=%h, required 0/220000aa", r_fault, instr);
        end
    endtask

    task automatic test_reset_busy();
        mem_rdata = 32'h4040_4040;
        addr_in   = 32'd240;
        req       = 1'b1;
        tick();
        req = 1'b0;
        tick();
        n_vec++;
        if (stall !== 1'b1) begin
            n_err++;
            $display("FAIL busy240_stall: %b, required 1", stall);
        end
        #2 reset_n = 1'b0;
        #1;
        n_vec++;
        if ({mem_en, instr_valid, stall, fault} !== 4'b0000 || instr !== 32'h0 || mem_addr !== 8'h00) begin
            n_err++;
            $display("FAIL async_reset: en=%b v=%b st=%b f=%b instr=%h maddr=%h, required all 0",
                     mem_en, instr_valid, stall, fault, instr, mem_addr);
        end
        tick();
        n_vec++;
        if (instr_valid !== 1'b0 || stall !== 1'b0) begin
            n_err++;
            $display("FAIL reset_hold: v=%b st=%b, required 0/0", instr_valid, stall);
        end
        reset_n = 1'b1;
        tick();
        run_req(32'd212, 32'h7777_0212, -1);
        n_vec++;
        if (r_memen !== 1 || r_stall !== 3 || r_valid !== 1 || r_vinstr !== 32'h7777_0212) begin
            n_err++;
            $display("FAIL miss212_after_reset: en=%0d st=%0d v=%0d instr=%h, required 1/3/1/77770212",
                     r_memen, r_stall, r_valid, r_vinstr);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_miss_first();
        test_fault();
        test_hit();
        test_flush_busy();
        test_flush_capture();
        test_reset_busy();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ifetch_responder.md
Name: ifetch_responder

Overview:
- Memory-side responder to the program counter's address stream.
- Accepts a fetch request for a PC address and checks it against the program window.
- Issues a single read to the synchronous instruction memory and waits a fixed, parameterised latency.
- Returns the instruction word, and drives the stall signal the PC uses to hold its address; a single-entry last-fetch buffer serves repeat fetches without touching memory.

Parameters:
ADDR_LO, 212, lowest legal fetch address (inclusive)
ADDR_HI, 255, highest legal fetch address (inclusive)
MEM_LATENCY, 3, cycles from request acceptance to data capture; legal range 1..15
MEM_AW, 8, instruction memory address width
NOP_WORD, 32'h00000000, instruction returned on fault

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
req  in  1  fetch request, sampled only in IDLE
addr_in  in  32  fetch address (PC aout)
flush  in  1  branch taken (pcsel); aborts any in-flight fetch
mem_en  out  1  memory read strobe
mem_addr  out  MEM_AW  memory read address = addr_in[MEM_AW-1:0] latched
mem_rdata  in  32  memory read data
instr  out  32  returned instruction, held until next return/fault
instr_valid  out  1  one-cycle pulse when instr is new
stall  out  1  high while a memory fetch is outstanding
fault  out  1  one-cycle pulse on out-of-window request

Behaviour:
- Reset (reset_n low, asynchronous): state IDLE; mem_en, instr_valid, stall, fault = 0; instr = 0; mem_addr = 0; count = 0; buffer invalid. Reset mid-BUSY abandons the fetch, with no instr_valid.
- Registers: all outputs are registered. Let E0 be the edge at which req is sampled high in IDLE.
- Window check: 32-bit unsigned; legal iff ADDR_LO <= addr_in <= ADDR_HI.
- IDLE with req=1 and flush=0 — three cases:
  - Fault (address illegal): after E0, fault=1 for one cycle and instr=NOP_WORD. No mem_en, no instr_valid, buffer unchanged, stay IDLE.
  - Hit (legal, buffer valid, addr_in == buffered address): after E0, instr = buffered word and instr_valid=1 for one cycle. No mem_en, no stall, stay IDLE.
  - Miss (legal, otherwise): after E0, state BUSY, mem_en=1 for exactly one cycle, mem_addr latched, stall=1, count=MEM_LATENCY.
- BUSY:
  - Each edge decrements count.
  - At the edge where count==1 (edge E_MEM_LATENCY): capture mem_rdata into instr and into the buffer (with the latched full 32-bit address), set the buffer valid, instr_valid=1 for one cycle, stall=0, return to IDLE.
  - Net effect: stall is high for exactly MEM_LATENCY cycles. The memory must present data by edge E_MEM_LATENCY.
- req in BUSY: ignored. The requester holds its address while stall is high.
- flush:
  - In BUSY: at that edge go to IDLE, stall=0, mem_en=0, no instr_valid. Memory data is discarded; instr and buffer are unchanged.
  - In IDLE with req=1 at the same edge: flush wins and the request is dropped (no response of any kind).
  - flush does not invalidate the buffer.
- flush coinciding with the capture edge (count==1): flush wins, with no instr_valid and no buffer update.
- MEM_LATENCY=1: accept at E0, capture at E1, stall high for one cycle.
- instr_valid and fault are never high in the same cycle. mem_en is never high outside the first BUSY cycle.

Test Plan:
- Reset, then req=1, addr_in=212, MEM_LATENCY=3, mem_rdata=32'hDEADBEEF -> mem_en high one cycle with mem_addr=8'hD4; stall high 3 cycles; instr_valid pulses with instr=32'hDEADBEEF the cycle stall falls.
- Repeat req at 212 after the first fetch -> instr_valid the cycle after E0, instr=32'hDEADBEEF, mem_en and stall stay 0. Then req at 213 -> full miss with 3-cycle stall.
- req with addr_in=211, then addr_in=256 -> fault pulse each time, instr=NOP_WORD, instr_valid=0, mem_en=0. A following req at 212 still hits the buffer.
- Miss at 220, flush asserted at the 2nd BUSY edge -> stall drops after that edge, no instr_valid; instr keeps its previous value. A following req at 220 is a miss, not a hit.
- Miss at 230, flush on the capture edge -> no instr_valid, buffer not updated. Separately, req and flush at the same edge in IDLE -> no mem_en, no fault, no instr_valid.
- Miss at 240, reset_n pulsed low asynchronously mid-BUSY -> all outputs 0 immediately. A following req at 212 is a miss (buffer invalid).
